ddr_burst_responder: RTL and testbench
======================================

Name: ddr_burst_responder

Overview:
- Responder end of the burst interface that the DDR cache interface drives: rd/wr_burst_req, len, addr, data, valid, data_req, finish.
- Services bursts from an on-chip BRAM memory model, so the associative-processor cache path runs on boards or benches without MIG/DDR.
- Drop-in replacement for the ddr_controller on that interface.

Parameters:
- DDR_DATA_WIDTH, 128, beat width.
- DDR_ADDR_WIDTH, 28, burst address width.
- MEM_ADDR_WIDTH, 16, log2 of memory depth in beats.
- ADDR_SHIFT, 3, byte-address to beat-index shift; beat index = (addr >> ADDR_SHIFT) mod 2^MEM_ADDR_WIDTH.
- RD_LATENCY, 2, cycles from read-address issue to rd_burst_data_valid; range 1..4.
- GUARD_CYCLES, 2, IDLE cycles after a finish before requests are sampled again.

Ports:
- mem_clk  in  1  clock
- rst  in  1  reset
- rd_burst_req  in  1  read request, level
- wr_burst_req  in  1  write request, level
- rd_burst_len  in  10  read beats
- wr_burst_len  in  10  write beats
- rd_burst_addr  in  DDR_ADDR_WIDTH  read start address
- wr_burst_addr  in  DDR_ADDR_WIDTH  write start address
- wr_burst_data  in  DDR_DATA_WIDTH  write beat, valid the cycle after wr_burst_data_req
- rd_burst_data  out  DDR_DATA_WIDTH  read beat
- rd_burst_data_valid  out  1  read beat strobe
- wr_burst_data_req  out  1  write beat request
- rd_burst_finish  out  1  one-cycle pulse at end of read burst
- wr_burst_finish  out  1  one-cycle pulse at end of write burst
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst asynchronous, active-high; clock mem_clk.
  - All outputs reset to 0; state = IDLE; guard counter loads GUARD_CYCLES.
  - Memory contents are not cleared by reset, including reset mid-burst.
  - A reset mid-burst aborts the burst with no finish pulse.
- States: IDLE, WR_BURST, WR_LAST, WR_END, RD_BURST, RD_DRAIN, RD_END.
- IDLE:
  - Decrements the guard counter to 0. Requests are sampled only when the guard counter is 0.
  - wr_burst_req has priority over rd_burst_req when both are high.
  - On accept, latch base beat index and len (10 bits); beat counter = 0.
  - len = 0: go straight to WR_END/RD_END, giving a finish pulse 2 cycles after the accept edge with no beats and no memory access.
- WR_BURST:
  - wr_burst_data_req is high for exactly len consecutive cycles, starting the cycle after accept.
  - Beat k is captured from wr_burst_data one cycle after its req cycle and written to index (base+k) mod depth.
  - After the last req cycle go to WR_LAST, which captures the final beat.
  - WR_END: wr_burst_finish = 1 for one cycle, then IDLE with the guard counter reloaded.
- RD_BURST:
  - Issues one read address per cycle, len cycles, starting the cycle after accept.
  - Data returns RD_LATENCY cycles after issue with rd_burst_data_valid = 1. Valid beats are consecutive, in address order.
  - RD_DRAIN waits for the last valid beat.
  - RD_END asserts rd_burst_finish for one cycle, in the cycle after the last valid; valid is 0 during the finish cycle. Then IDLE with guard reloaded.
- rd_burst_data holds the last beat while valid = 0.
- Wrap-around: beat index wraps modulo 2^MEM_ADDR_WIDTH mid-burst with no error.
- Request changes during a burst are ignored; addr and len stay latched until END.
- A request still high after the guard expires starts a new burst. The initiator must drop the request, or change it, during the finish cycle or the guard window.
- Read-after-write: a read accepted after WR_END returns the newly written data; no bypass is needed because of the guard.

Optional Feature:
- Macro: DDR_BURST_RESP_STATS_EN.
- When defined:
  - Extra outputs wr_burst_cnt[15:0] and rd_burst_cnt[15:0], reset to 0.
  - Each increments on its finish pulse, zero-length bursts included, and saturates at 16'hFFFF.
- When not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package ddr_burst_pkg:
  - State encodings (3-bit localparams).
  - LEN_WIDTH = 10.
  - Default widths shared with the cache interface: 128/28.
- Sub-module ddr_resp_mem: simple dual-port RAM with one write port and one read port, whose read path is pipelined to RD_LATENCY.
- The responder FSM, counters and guard stay in ddr_burst_responder.

Test Plan:
1. Reset, then wr_burst_req = 1, len = 64, addr = 0 with data = beat index → data_req high 64 cycles, wr_burst_finish pulse; busy falls; memory [0..63] = 0..63.
2. Read len = 17 at addr 0x0008000 after writing 65 beats of 16'hA5A0 + k there → valid beats 17 consecutive cycles starting accept + 1 + RD_LATENCY; data A5A0..A5B0; finish pulse the cycle after the last valid.
3. rd_burst_req and wr_burst_req both high in IDLE → write serviced first; read starts GUARD_CYCLES after wr_burst_finish.
4. len = 0 write, then len = 0 read → finish pulse 2 cycles after each accept; no data_req or valid; memory unchanged.
5. Write len = 4 at beat index 2^MEM_ADDR_WIDTH − 2 → beats land at indices depth−2, depth−1, 0, 1; read-back matches.
6. Assert rst at beat 5 of a 16-beat read → outputs 0 immediately, no finish pulse; a new read after reset returns the previously written data intact.

Source files
------------

// File: rtl/ddr_burst_pkg.sv
// ---------------------------------------------------------------------------
// ddr_burst_pkg
//
// Shared definitions for the BRAM-backed DDR burst responder and the cache
// interface that drives it: default bus widths, the burst length width and
// the responder state encoding.
//
// No ports (package).
// ---------------------------------------------------------------------------
package ddr_burst_pkg;

  // Widths shared with the DDR cache interface.
  localparam int DDR_DATA_WIDTH_DEF = 128;
  localparam int DDR_ADDR_WIDTH_DEF = 28;

  // Burst length field width (rd_burst_len / wr_burst_len).
  localparam int LEN_WIDTH = 10;

  // Responder state encodings. Exported as raw 3-bit values so the debug
  // state output can be decoded without the enum type.
  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_WR_BURST = 3'd1;
  localparam logic [2:0] ENC_WR_LAST  = 3'd2;
  localparam logic [2:0] ENC_WR_END   = 3'd3;
  localparam logic [2:0] ENC_RD_BURST = 3'd4;
  localparam logic [2:0] ENC_RD_DRAIN = 3'd5;
  localparam logic [2:0] ENC_RD_END   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_WR_BURST = ENC_WR_BURST,
    ST_WR_LAST  = ENC_WR_LAST,
    ST_WR_END   = ENC_WR_END,
    ST_RD_BURST = ENC_RD_BURST,
    ST_RD_DRAIN = ENC_RD_DRAIN,
    ST_RD_END   = ENC_RD_END
  } state_t;

endpackage

// File: rtl/ddr_resp_mem.sv
// ---------------------------------------------------------------------------
// ddr_resp_mem
//
// Simple dual-port RAM backing the burst responder: one synchronous write
// port and one read port whose output is pipelined to RD_LATENCY cycles.
// A read issued in cycle c (re = 1) appears on rdata with rvalid = 1 in
// cycle c + RD_LATENCY. rdata only updates on valid beats, so it holds the
// last returned beat while rvalid = 0.
//
// The storage array has no reset: contents survive rst. Only the read
// pipeline (data and valid) is cleared by rst.
//
// Ports:
//   mem_clk  in   clock
//   rst      in   asynchronous active-high reset (read pipeline only)
//   we       in   write enable
//   waddr    in   write beat index
//   wdata    in   write beat
//   re       in   read issue strobe
//   raddr    in   read beat index
//   rdata    out  read beat, RD_LATENCY cycles after issue
//   rvalid   out  read beat strobe
// ---------------------------------------------------------------------------
module ddr_resp_mem
  import ddr_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DDR_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2  // legal range 1..4
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Stage 0 is the RAM output register; stages 1..RD_LATENCY-1 are delay.
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_q;

  always_ff @(posedge mem_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= re;
      if (re) begin
        dat_q[0] <= mem[raddr];
      end
      // Data only moves with its valid bit, which gives the hold-last-beat
      // behaviour at the output for free.
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign rdata  = dat_q[RD_LATENCY-1];
  assign rvalid = vld_q[RD_LATENCY-1];

endmodule

// File: rtl/ddr_burst_responder.sv
// ---------------------------------------------------------------------------
// ddr_burst_responder
//
// Responder end of the DDR cache burst interface, serviced from an on-chip
// BRAM model (ddr_resp_mem) instead of MIG/DDR. Drop-in replacement for
// ddr_controller on that interface.
//
// Handshake (one place, applies to the whole interface):
//   - rd_burst_req / wr_burst_req are levels. They are sampled only in IDLE
//     once the guard counter has reached 0; write wins if both are high.
//     On accept, address and len are latched and further request, address
//     and len changes are ignored until the burst ends.
//   - Write: wr_burst_data_req is high for exactly len consecutive cycles
//     starting the cycle after accept. The initiator presents beat k on
//     wr_burst_data in the cycle after the k-th data_req cycle.
//   - Read: rd_burst_data_valid is high for exactly len consecutive cycles,
//     beats in address order, first beat RD_LATENCY+1 cycles after accept.
//   - The finish pulse is one cycle wide and comes in the cycle after the
//     END state (for len = 0: 2 cycles after the accept edge; for reads:
//     the cycle after the last valid beat). The initiator drops or changes
//     its request during the finish cycle or the guard window; a request
//     still high after the guard starts a new burst.
//
// Beat index = (addr >> ADDR_SHIFT) mod 2^MEM_ADDR_WIDTH; bursts wrap.
//
// Optional feature (macro DDR_BURST_RESP_STATS_EN): adds wr_burst_cnt and
// rd_burst_cnt, saturating 16-bit counts of finish pulses.
//
// Ports:
//   mem_clk, rst          clock, asynchronous active-high reset
//   rd/wr_burst_req       burst requests (levels)
//   rd/wr_burst_len       burst length in beats
//   rd/wr_burst_addr      burst start address
//   wr_burst_data         write beat
//   rd_burst_data         read beat (holds last beat while valid = 0)
//   rd_burst_data_valid   read beat strobe
//   wr_burst_data_req     write beat request
//   rd/wr_burst_finish    one-cycle end-of-burst pulses
//   busy                  high in any state except IDLE
//   state_dbg             current state encoding (ENC_* in ddr_burst_pkg)
//   wr/rd_burst_cnt       finish counters (DDR_BURST_RESP_STATS_EN only)
// ---------------------------------------------------------------------------
module ddr_burst_responder
  import ddr_burst_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = DDR_DATA_WIDTH_DEF,
  parameter int DDR_ADDR_WIDTH = DDR_ADDR_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int ADDR_SHIFT     = 3,
  parameter int RD_LATENCY     = 2,  // legal range 1..4
  parameter int GUARD_CYCLES   = 2
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      rd_burst_req,
  input  logic                      wr_burst_req,
  input  logic [LEN_WIDTH-1:0]      rd_burst_len,
  input  logic [LEN_WIDTH-1:0]      wr_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
  output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic                      rd_burst_finish,
  output logic                      wr_burst_finish,
  output logic                      busy,
  output logic [2:0]                state_dbg
`ifdef DDR_BURST_RESP_STATS_EN
  ,
  output logic [15:0]               wr_burst_cnt,
  output logic [15:0]               rd_burst_cnt
`endif
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  // RD_DRAIN lasts RD_LATENCY-1 cycles so that RD_END coincides with the
  // last valid beat and the finish pulse lands in the cycle after it.
  localparam logic [1:0] DRAIN_LOAD = 2'((RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0);

  state_t                    state;
  logic [GW-1:0]             guard_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      beat_cnt;   // requests / read addresses issued
  logic [1:0]                drain_cnt;
  logic [MEM_ADDR_WIDTH-1:0] rd_idx_q;   // next read beat index
  logic [MEM_ADDR_WIDTH-1:0] wr_idx_q;   // next write beat index to capture
  logic                      wr_cap_q;   // data_req was high last cycle

  logic [MEM_ADDR_WIDTH-1:0] rd_base;
  logic [MEM_ADDR_WIDTH-1:0] wr_base;
  logic                      mem_re;

  // The cast truncation is the mod 2^MEM_ADDR_WIDTH of the beat index.
  assign rd_base = MEM_ADDR_WIDTH'(rd_burst_addr >> ADDR_SHIFT);
  assign wr_base = MEM_ADDR_WIDTH'(wr_burst_addr >> ADDR_SHIFT);

  assign mem_re    = (state == ST_RD_BURST);
  assign state_dbg = state;

  ddr_resp_mem #(
    .DATA_WIDTH (DDR_DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_mem (
    .mem_clk (mem_clk),
    .rst     (rst),
    .we      (wr_cap_q),
    .waddr   (wr_idx_q),
    .wdata   (wr_burst_data),
    .re      (mem_re),
    .raddr   (rd_idx_q),
    .rdata   (rd_burst_data),
    .rvalid  (rd_burst_data_valid)
  );

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      guard_q           <= GUARD_LOAD;
      len_q             <= '0;
      beat_cnt          <= '0;
      drain_cnt         <= '0;
      rd_idx_q          <= '0;
      wr_idx_q          <= '0;
      wr_cap_q          <= 1'b0;
      wr_burst_data_req <= 1'b0;
      wr_burst_finish   <= 1'b0;
      rd_burst_finish   <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // Finish pulses are the END states delayed by one cycle.
      wr_burst_finish <= (state == ST_WR_END);
      rd_burst_finish <= (state == ST_RD_END);

      // Write beats trail their request by one cycle; each captured beat
      // advances the write index (wraps naturally at the memory depth).
      wr_cap_q <= wr_burst_data_req;
      if (wr_cap_q) begin
        wr_idx_q <= wr_idx_q + MEM_ADDR_WIDTH'(1);
      end

      case (state)
        ST_IDLE: begin
          if (guard_q != '0) begin
            guard_q <= guard_q - GW'(1);
          end else if (wr_burst_req) begin
            busy     <= 1'b1;
            len_q    <= wr_burst_len;
            wr_idx_q <= wr_base;
            beat_cnt <= '0;
            if (wr_burst_len == '0) begin
              state <= ST_WR_END;
            end else begin
              state             <= ST_WR_BURST;
              wr_burst_data_req <= 1'b1;
            end
          end else if (rd_burst_req) begin
            busy     <= 1'b1;
            len_q    <= rd_burst_len;
            rd_idx_q <= rd_base;
            beat_cnt <= '0;
            state    <= (rd_burst_len == '0) ? ST_RD_END : ST_RD_BURST;
          end
        end

        ST_WR_BURST: begin
          if (beat_cnt == len_q - LEN_WIDTH'(1)) begin
            wr_burst_data_req <= 1'b0;
            state             <= ST_WR_LAST;
          end else begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          end
        end

        // The final beat is captured here via wr_cap_q.
        ST_WR_LAST: state <= ST_WR_END;

        ST_RD_BURST: begin
          rd_idx_q <= rd_idx_q + MEM_ADDR_WIDTH'(1);
          if (beat_cnt == len_q - LEN_WIDTH'(1)) begin
            if (RD_LATENCY == 1) begin
              state <= ST_RD_END;
            end else begin
              state     <= ST_RD_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          end
        end

        ST_RD_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_RD_END;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end

        ST_WR_END, ST_RD_END: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          guard_q <= GUARD_LOAD;
        end

        default: begin
          state             <= ST_IDLE;
          busy              <= 1'b0;
          wr_burst_data_req <= 1'b0;
          guard_q           <= GUARD_LOAD;
        end
      endcase
    end
  end

`ifdef DDR_BURST_RESP_STATS_EN
  // Counts step on the same edge the finish pulse rises; zero-length
  // bursts count too. Both saturate.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
    end else begin
      if (state == ST_WR_END && wr_burst_cnt != 16'hFFFF) begin
        wr_burst_cnt <= wr_burst_cnt + 16'd1;
      end
      if (state == ST_RD_END && rd_burst_cnt != 16'hFFFF) begin
        rd_burst_cnt <= rd_burst_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddr_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_responder
//
// Directed bench for ddr_burst_responder with default parameters
// (RD_LATENCY = 2, GUARD_CYCLES = 2, MEM_ADDR_WIDTH = 16, ADDR_SHIFT = 3).
// Inputs change and outputs are sampled on the falling edge. Cycle 1 of a
// burst is the first cycle in which busy is seen high (the cycle after the
// accept edge).
// ---------------------------------------------------------------------------
module tb_ddr_burst_responder;

  localparam int DW    = 128;
  localparam int AW    = 28;
  localparam int MAW   = 16;
  localparam int DEPTH = 1 << MAW;
  localparam int RL    = 2;
  localparam int GUARD = 2;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic          mem_clk = 1'b0;
  logic          rst;
  logic          rd_burst_req, wr_burst_req;
  logic [9:0]    rd_burst_len, wr_burst_len;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic [DW-1:0] wr_burst_data;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_data_valid, wr_burst_data_req;
  logic          rd_burst_finish, wr_burst_finish, busy;
  logic [2:0]    state_dbg;
`ifdef DDR_BURST_RESP_STATS_EN
  logic [15:0]   wr_burst_cnt, rd_burst_cnt;
`endif

  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  ddr_burst_responder dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .rd_burst_req        (rd_burst_req),
    .wr_burst_req        (wr_burst_req),
    .rd_burst_len        (rd_burst_len),
    .wr_burst_len        (wr_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data       (wr_burst_data),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_data_valid (rd_burst_data_valid),
    .wr_burst_data_req   (wr_burst_data_req),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_finish     (wr_burst_finish),
    .busy                (busy),
    .state_dbg           (state_dbg)
`ifdef DDR_BURST_RESP_STATS_EN
    ,
    .wr_burst_cnt        (wr_burst_cnt),
    .rd_burst_cnt        (rd_burst_cnt)
`endif
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [DW-1:0] model [int];   // beat index -> last written beat
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int last_fin_cyc  = 0;
  int last_rise_cyc = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int beat_idx(input logic [AW-1:0] addr, input int k);
    return int'((int'(addr >> 3) + k) % DEPTH);
  endfunction

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge mem_clk);
      if (busy) begin
        ok = 1'b1;
        last_rise_cyc = cyc;
        return;
      end
    end
  endtask

  // Caller has already raised wr_burst_req with addr/len applied.
  task automatic service_write(input logic [AW-1:0] addr, input int len,
                               input logic [DW-1:0] d0, input string tag);
    bit ok;
    bit prev_req  = 1'b0;
    bit saw_valid = 1'b0;
    int nreq = 0, first = 0, last = 0, fin = 0, k = 0;
    wait_accept(ok);
    check_eq({tag, "_accept"}, DW'(ok), DW'(1));
    if (!ok) begin
      wr_burst_req = 1'b0;
      return;
    end
    for (int c = 1; c <= len + 12; c++) begin
      if (prev_req) begin
        wr_burst_data = d0 + DW'(k);
        k++;
      end
      if (wr_burst_data_req) begin
        nreq++;
        if (first == 0) first = c;
        last = c;
      end
      if (rd_burst_data_valid) saw_valid = 1'b1;
      if (wr_burst_finish) begin
        fin = c;
        last_fin_cyc = cyc;
        wr_burst_req = 1'b0;
        break;
      end
      prev_req = wr_burst_data_req;
      @(negedge mem_clk);
    end
    check_eq({tag, "_req_count"}, DW'(nreq), DW'(len));
    check_eq({tag, "_req_first"}, DW'(first), DW'((len > 0) ? 1 : 0));
    check_eq({tag, "_req_last"}, DW'(last), DW'(len));
    check_eq({tag, "_finish_cyc"}, DW'(fin), DW'((len == 0) ? 2 : len + 3));
    check_eq({tag, "_no_rd_valid"}, DW'(saw_valid), DW'(0));
    @(negedge mem_clk);
    check_eq({tag, "_finish_1cyc"}, DW'(wr_burst_finish), DW'(0));
    for (int j = 0; j < len; j++) model[beat_idx(addr, j)] = d0 + DW'(j);
  endtask

  // Caller has already raised rd_burst_req with addr/len applied.
  task automatic service_read(input logic [AW-1:0] addr, input int len,
                              input string tag);
    bit ok;
    bit saw_req = 1'b0;
    int nval = 0, first = 0, last = 0, fin = 0;
    logic [DW-1:0] hold_exp = '0;
    exp_q.delete();
    for (int j = 0; j < len; j++) begin
      exp_q.push_back(model[beat_idx(addr, j)]);
      hold_exp = model[beat_idx(addr, j)];
    end
    wait_accept(ok);
    check_eq({tag, "_accept"}, DW'(ok), DW'(1));
    if (!ok) begin
      rd_burst_req = 1'b0;
      return;
    end
    for (int c = 1; c <= len + RL + 12; c++) begin
      if (rd_burst_data_valid) begin
        nval++;
        if (first == 0) first = c;
        last = c;
        if (exp_q.size() > 0) check_eq({tag, "_beat"}, rd_burst_data, exp_q.pop_front());
      end
      if (wr_burst_data_req) saw_req = 1'b1;
      if (rd_burst_finish) begin
        fin = c;
        last_fin_cyc = cyc;
        check_eq({tag, "_valid_at_finish"}, DW'(rd_burst_data_valid), DW'(0));
        if (len > 0) check_eq({tag, "_data_hold"}, rd_burst_data, hold_exp);
        rd_burst_req = 1'b0;
        break;
      end
      @(negedge mem_clk);
    end
    check_eq({tag, "_valid_count"}, DW'(nval), DW'(len));
    check_eq({tag, "_valid_first"}, DW'(first), DW'((len > 0) ? RL + 1 : 0));
    check_eq({tag, "_valid_last"}, DW'(last), DW'((len > 0) ? len + RL : 0));
    check_eq({tag, "_finish_cyc"}, DW'(fin), DW'((len == 0) ? 2 : len + RL + 1));
    check_eq({tag, "_no_wr_req"}, DW'(saw_req), DW'(0));
    @(negedge mem_clk);
    check_eq({tag, "_finish_1cyc"}, DW'(rd_burst_finish), DW'(0));
  endtask

  task automatic start_wr(input logic [AW-1:0] addr, input int len);
    wr_burst_addr = addr;
    wr_burst_len  = 10'(len);
    wr_burst_req  = 1'b1;
  endtask

  task automatic start_rd(input logic [AW-1:0] addr, input int len);
    rd_burst_addr = addr;
    rd_burst_len  = 10'(len);
    rd_burst_req  = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int wr_fin;
    int nval;
    bit got5;

    rst           = 1'b1;
    rd_burst_req  = 1'b0;
    wr_burst_req  = 1'b0;
    rd_burst_len  = '0;
    wr_burst_len  = '0;
    rd_burst_addr = '0;
    wr_burst_addr = '0;
    wr_burst_data = '0;

    repeat (3) @(negedge mem_clk);
    check_eq("rst_valid", DW'(rd_burst_data_valid), DW'(0));
    check_eq("rst_data", rd_burst_data, DW'(0));
    check_eq("rst_wr_req", DW'(wr_burst_data_req), DW'(0));
    check_eq("rst_rd_fin", DW'(rd_burst_finish), DW'(0));
    check_eq("rst_wr_fin", DW'(wr_burst_finish), DW'(0));
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_state", DW'(state_dbg), DW'(0));
    rst = 1'b0;
    @(negedge mem_clk);

    // 1: 64-beat write at 0 with data = beat index, then read it back.
    start_wr(28'h0, 64);
    service_write(28'h0, 64, 128'h0, "t1_wr");
    check_eq("t1_busy_low", DW'(busy), DW'(0));
    start_rd(28'h0, 64);
    service_read(28'h0, 64, "t1_rd");

    // 2: 65 beats of A5A0+k at 0x0008000, read 17 back (A5A0..A5B0).
    start_wr(28'h0008000, 65);
    service_write(28'h0008000, 65, 128'hA5A0, "t2_wr");
    start_rd(28'h0008000, 17);
    service_read(28'h0008000, 17, "t2_rd");

    // 3: both requests together; write first, read after the guard and it
    // sees the freshly written data.
    start_wr(28'h200, 3);
    start_rd(28'h200, 3);
    service_write(28'h200, 3, 128'hBEEF00, "t3_wr");
    wr_fin = last_fin_cyc;
    service_read(28'h200, 3, "t3_rd");
    check_eq("t3_guard_gap", DW'(last_rise_cyc - wr_fin), DW'(GUARD + 1));
    check_eq("t3_raw_model", model[64], 128'hBEEF00);

    // 4: zero-length write and read; memory at 0 unchanged afterwards.
    start_wr(28'h0, 0);
    service_write(28'h0, 0, 128'hDEAD, "t4_wr");
    start_rd(28'h0, 0);
    service_read(28'h0, 0, "t4_rd");
    start_rd(28'h0, 2);
    service_read(28'h0, 2, "t4_unchanged");

    // 5: write 4 beats starting at beat index depth-2 (addr 0x7FFF0), wrap.
    start_wr(28'h7FFF0, 4);
    service_write(28'h7FFF0, 4, 128'hC0DE0000, "t5_wr");
    start_rd(28'h7FFF0, 4);
    service_read(28'h7FFF0, 4, "t5_rd");
    start_rd(28'h0, 2);
    service_read(28'h0, 2, "t5_wrap_low");
    check_eq("t5_idx0", model[0], 128'hC0DE0002);
    check_eq("t5_idx1", model[1], 128'hC0DE0003);

    // 6: reset during beat 5 of a 16-beat read, then read again.
    start_rd(28'h0008000, 16);
    nval = 0;
    got5 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge mem_clk);
      if (rd_burst_data_valid) nval++;
      if (nval == 5) begin
        got5 = 1'b1;
        break;
      end
    end
    check_eq("t6_reached_beat5", DW'(got5), DW'(1));
    rst = 1'b1;
    rd_burst_req = 1'b0;
    #1;
    check_eq("t6_rst_valid", DW'(rd_burst_data_valid), DW'(0));
    check_eq("t6_rst_data", rd_burst_data, DW'(0));
    check_eq("t6_rst_busy", DW'(busy), DW'(0));
    check_eq("t6_rst_state", DW'(state_dbg), DW'(0));
    repeat (2) @(negedge mem_clk);
    check_eq("t6_no_finish", DW'(rd_burst_finish), DW'(0));
    rst = 1'b0;
    @(negedge mem_clk);
    check_eq("t6_no_finish_after", DW'(rd_burst_finish), DW'(0));
    start_rd(28'h0008000, 16);
    service_read(28'h0008000, 16, "t6_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
